// File: rtl/rx_lane_fifo_pkg.sv
// Shared PHY RX lane definitions: default lane geometry and the pause FSM encoding.
package rx_lane_fifo_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 8;

   typedef enum logic {
      RUN   = 1'b0,
      PAUSE = 1'b1
   } pause_state_t;

endpackage

// File: rtl/rx_lane_fifo_mem.sv
// DEPTH x DATA_W lane register file: one synchronous write port, one registered read port with enable.
module rx_lane_fifo_mem
   import rx_lane_fifo_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic [DATA_W-1:0] rd_data_reg;

   // Array kept reset-free so it maps onto RAM; only the output register clears.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_reg[wr_addr] <= wr_data;
      end
   end

   // Same-address read/write (full FIFO, push+pop) returns the old word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_reg <= '0;
      end else if (rd_en) begin
         rd_data_reg <= mem_reg[rd_addr];
      end
   end

   assign rd_data = rd_data_reg;

endmodule

// File: rtl/rx_lane_fifo.sv
// Per-lane RX FIFO behind the byte demux: pointers, occupancy, fill flags,
// hysteretic pause request and sticky overflow/underflow flags.
module rx_lane_fifo
   import rx_lane_fifo_pkg::*;
#(
   parameter  int DATA_W = DATA_W_DEF,
   parameter  int DEPTH  = DEPTH_DEF,
   localparam int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_valid,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic [AW:0]       umbral_af,
   input  logic [AW:0]       umbral_ae,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_valid,
   output logic [AW:0]       count,
   output logic              full,
   output logic              empty,
   output logic              almost_full,
   output logic              almost_empty,
   output logic              pause,
   output logic              overflow_err,
   output logic              underflow_err
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [AW:0]   count_reg, count_next;
   logic          pop_valid_reg;
   logic          overflow_reg, underflow_reg;
   pause_state_t  state_reg, state_next;
   logic          push_acc, pop_acc;

   assign full         = (count_reg == FULL_CNT);
   assign empty        = (count_reg == '0);
   assign almost_full  = (count_reg >= umbral_af);
   assign almost_empty = (count_reg <= umbral_ae);

   // No bypass: a pop on an empty FIFO never sees the same-cycle push.
   assign pop_acc  = pop && !empty;
   assign push_acc = push_valid && (!full || pop_acc);

   always_comb begin
      wr_ptr_next = push_acc ? wr_ptr_reg + AW'(1) : wr_ptr_reg;
      rd_ptr_next = pop_acc  ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
      count_next  = count_reg;
      case ({push_acc, pop_acc})
         2'b10:   count_next = count_reg + (AW+1)'(1);
         2'b01:   count_next = count_reg - (AW+1)'(1);
         default: count_next = count_reg;
      endcase
   end

   // Conflicting thresholds (both flags high) hold the current state.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         RUN:     if (almost_full && !almost_empty) state_next = PAUSE;
         PAUSE:   if (almost_empty && !almost_full) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         pop_valid_reg <= 1'b0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
         state_reg     <= RUN;
      end else begin
         wr_ptr_reg    <= wr_ptr_next;
         rd_ptr_reg    <= rd_ptr_next;
         count_reg     <= count_next;
         pop_valid_reg <= pop_acc;
         state_reg     <= state_next;
         if (push_valid && !push_acc) overflow_reg  <= 1'b1;
         if (pop && !pop_acc)         underflow_reg <= 1'b1;
      end
   end

   rx_lane_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push_acc),
      .wr_addr (wr_ptr_reg),
      .wr_data (push_data),
      .rd_en   (pop_acc),
      .rd_addr (rd_ptr_reg),
      .rd_data (pop_data)
   );

   assign pop_valid     = pop_valid_reg;
   assign count         = count_reg;
   assign pause         = (state_reg == PAUSE);
   assign overflow_err  = overflow_reg;
   assign underflow_err = underflow_reg;

endmodule

// File: tb/tb_rx_lane_fifo.sv
// Directed self-checking bench for rx_lane_fifo (DATA_W 8, DEPTH 8).
module tb_rx_lane_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic       push_valid;
   logic [7:0] push_data;
   logic       pop;
   logic [3:0] umbral_af;
   logic [3:0] umbral_ae;
   logic [7:0] pop_data;
   logic       pop_valid;
   logic [3:0] count;
   logic       full, empty, almost_full, almost_empty, pause;
   logic       overflow_err, underflow_err;

   int n_compared   = 0;
   int n_mismatched = 0;

   rx_lane_fifo #(.DATA_W(8), .DEPTH(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .push_valid    (push_valid),
      .push_data     (push_data),
      .pop           (pop),
      .umbral_af     (umbral_af),
      .umbral_ae     (umbral_ae),
      .pop_data      (pop_data),
      .pop_valid     (pop_valid),
      .count         (count),
      .full          (full),
      .empty         (empty),
      .almost_full   (almost_full),
      .almost_empty  (almost_empty),
      .pause         (pause),
      .overflow_err  (overflow_err),
      .underflow_err (underflow_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Advance one clock; results are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] d);
      push_valid = 1'b1;
      push_data  = d;
      step();
      push_valid = 1'b0;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   logic [7:0] exp_t3 [8];

   initial begin
      exp_t3 = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
      reset      = 1'b0;
      push_valid = 1'b0;
      push_data  = 8'h00;
      pop        = 1'b0;
      umbral_af  = 4'd6;
      umbral_ae  = 4'd2;
      #3;
      check("rst_count", count, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_ae", almost_empty, 1);
      check("rst_af", almost_full, 0);
      check("rst_pause", pause, 0);
      check("rst_pop_valid", pop_valid, 0);
      check("rst_pop_data", pop_data, 0);
      check("rst_errs", {overflow_err, underflow_err}, 0);
      step();
      reset = 1'b1;

      // Fill to DEPTH, then one refused push
      for (int i = 1; i <= 8; i++) push_byte(8'(i));
      check("fill_count", count, 8);
      check("fill_full", full, 1);
      check("fill_ovf_clear", overflow_err, 0);
      push_byte(8'h09);
      check("ovf_set", overflow_err, 1);
      check("ovf_count", count, 8);

      // Drain: 0x09 must not appear
      pop = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step();
         check($sformatf("drain_data%0d", i), pop_data, i);
         check($sformatf("drain_valid%0d", i), pop_valid, 1);
      end
      pop = 1'b0;
      check("drain_empty", empty, 1);
      step();
      check("idle_valid", pop_valid, 0);
      check("idle_hold", pop_data, 8'h08);
      check("drain_no_unf", underflow_err, 0);

      // Full FIFO with simultaneous push and pop
      pulse_reset();
      check("rst2_ovf", overflow_err, 0);
      for (int i = 1; i <= 8; i++) push_byte(8'(i));
      push_valid = 1'b1;
      push_data  = 8'hAA;
      pop        = 1'b1;
      step();
      push_valid = 1'b0;
      check("pp_data", pop_data, 8'h01);
      check("pp_count", count, 8);
      check("pp_no_ovf", overflow_err, 0);
      for (int k = 0; k < 8; k++) begin
         step();
         check($sformatf("pp_drain%0d", k), pop_data, exp_t3[k]);
      end
      pop = 1'b0;
      check("pp_empty", empty, 1);

      // Empty FIFO with simultaneous push and pop: no bypass
      push_valid = 1'b1;
      push_data  = 8'h55;
      pop        = 1'b1;
      step();
      push_valid = 1'b0;
      check("ep_unf", underflow_err, 1);
      check("ep_count", count, 1);
      check("ep_valid", pop_valid, 0);
      step();
      check("ep_data", pop_data, 8'h55);
      check("ep_valid2", pop_valid, 1);
      check("ep_count2", count, 0);
      pop = 1'b0;

      // Pause hysteresis with af=6, ae=2
      pulse_reset();
      check("rst3_unf", underflow_err, 0);
      for (int i = 0; i < 6; i++) push_byte(8'h10 + 8'(i));
      check("hy_count6", count, 6);
      check("hy_af", almost_full, 1);
      check("hy_pause_lag", pause, 0);
      step();
      check("hy_pause_on", pause, 1);
      pop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("hy_hold%0d", i), pause, 1);
      end
      check("hy_count3", count, 3);
      step();
      pop = 1'b0;
      check("hy_count2", count, 2);
      check("hy_ae", almost_empty, 1);
      check("hy_pause_lag2", pause, 1);
      step();
      check("hy_pause_off", pause, 0);

      // Mid-stream asynchronous reset
      for (int i = 0; i < 4; i++) push_byte(8'h20 + 8'(i));
      step();
      check("mr_pause", pause, 1);
      pop = 1'b1;
      step();
      pop = 1'b0;
      check("mr_count5", count, 5);
      check("mr_pre_data", pop_data, 8'h14);
      check("mr_pre_valid", pop_valid, 1);
      reset = 1'b0;
      #1;
      check("mr_count", count, 0);
      check("mr_empty", empty, 1);
      check("mr_valid", pop_valid, 0);
      check("mr_data", pop_data, 0);
      check("mr_pause0", pause, 0);
      step();
      reset = 1'b1;
      push_byte(8'h77);
      pop = 1'b1;
      step();
      pop = 1'b0;
      check("mr_new_data", pop_data, 8'h77);
      check("mr_new_valid", pop_valid, 1);
      check("mr_new_count", count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
